// File: rtl/jtgng_ps2_pkg.sv
// Shared constants and types for the native PS/2 keyboard front-end.
package jtgng_ps2_pkg;

    // Prefix bytes folded into the following scan code
    localparam logic [7:0] PS2_EXT    = 8'hE0;
    localparam logic [7:0] PS2_BRK    = 8'hF0;
    localparam logic [7:0] PS2_PAUSE  = 8'hE1;

    // Bytes that follow E1 in the Pause make sequence and carry no key event
    localparam logic [2:0] PAUSE_TAIL = 3'd7;

    // Receiver bit-level states
    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

endpackage

// File: rtl/jtgng_ps2_rx.sv
// PS/2 device-to-host frame receiver: synchroniser, ps2_clk glitch filter,
// bit FSM and inter-edge timeout. Delivers one validated byte per frame.
module jtgng_ps2_rx
    import jtgng_ps2_pkg::*;
#(
    parameter int FILTER  = 4,
    parameter int TIMEOUT = 48000,
    parameter int TOW     = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       byte_vld,
    output logic       frame_err
);

    localparam int FW = $clog2(FILTER + 1);

    logic [1:0]     clk_sync;
    logic [1:0]     data_sync;
    logic           clk_flt;
    logic           clk_flt_q;
    logic [FW-1:0]  flt_cnt;
    logic           fall;
    logic           data_bit;

    rx_state_t      state;
    logic [7:0]     shreg;
    logic [2:0]     bit_cnt;
    logic           par_ok;
    logic           smp;
    logic [TOW-1:0] to_cnt;

    // Two-flop synchronisers; both lines reset to their idle-high level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync  <= 2'b11;
            data_sync <= 2'b11;
        end else begin
            // NOTE: non-blocking so each stage captures the previous stage's old value, forming a real shift chain.
            clk_sync  <= {clk_sync[0], ps2_clk};
            data_sync <= {data_sync[0], ps2_data};
        end
    end

    // ps2_clk glitch filter: accept a new level only after FILTER equal samples
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_flt   <= 1'b1;
            clk_flt_q <= 1'b1;
            flt_cnt   <= '0;
        end else begin
            clk_flt_q <= clk_flt;
            if (clk_sync[1] != clk_flt) begin
                if (flt_cnt == FW'(FILTER - 1)) begin
                    clk_flt <= clk_sync[1];
                    flt_cnt <= '0;
                end else begin
                    flt_cnt <= flt_cnt + 1'b1;
                end
            end else begin
                flt_cnt <= '0;
            end
        end
    end

    assign fall     = clk_flt_q & ~clk_flt;
    assign data_bit = data_sync[1];

    // Bit FSM with timeout; byte_vld and frame_err are registered one-cycle pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RX_IDLE;
            shreg     <= '0;
            bit_cnt   <= '0;
            par_ok    <= 1'b0;
            smp       <= 1'b1;
            to_cnt    <= '0;
            rx_byte   <= '0;
            byte_vld  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            byte_vld  <= 1'b0;
            frame_err <= 1'b0;

            // Counter saturates at TIMEOUT-1 instead of wrapping
            if (fall || state == RX_IDLE) begin
                to_cnt <= '0;
            end else if (to_cnt != TOW'(TIMEOUT - 1)) begin
                to_cnt <= to_cnt + 1'b1;
            end

            if (state != RX_IDLE && !fall && to_cnt == TOW'(TIMEOUT - 1)) begin
                // Device stalled mid-frame: drop the partial frame
                state     <= RX_IDLE;
                frame_err <= 1'b1;
            end else begin
                case (state)
                    RX_IDLE: begin
                        if (fall) begin
                            smp   <= data_bit;
                            state <= RX_START;
                        end
                    end
                    RX_START: begin
                        // A high start bit means we are not aligned to a frame
                        if (!smp) begin
                            bit_cnt <= '0;
                            state   <= RX_DATA;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= RX_IDLE;
                        end
                    end
                    RX_DATA: begin
                        if (fall) begin
                            shreg   <= {data_bit, shreg[7:1]};
                            bit_cnt <= bit_cnt + 1'b1;
                            if (bit_cnt == 3'd7) state <= RX_PARITY;
                        end
                    end
                    RX_PARITY: begin
                        if (fall) begin
                            par_ok <= ^{shreg, data_bit};
                            state  <= RX_STOP;
                        end
                    end
                    RX_STOP: begin
                        if (fall) begin
                            if (data_bit && par_ok) begin
                                rx_byte  <= shreg;
                                byte_vld <= 1'b1;
                            end else begin
                                frame_err <= 1'b1;
                            end
                            state <= RX_IDLE;
                        end
                    end
                    default: state <= RX_IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/jtgng_ps2_keydec.sv
// Native PS/2 keyboard front-end: folds E0/F0/E1 prefixes into single key
// events and presents them as the 11-bit toggle-strobed key word.
module jtgng_ps2_keydec
    import jtgng_ps2_pkg::*;
#(
    parameter int FILTER  = 4,
    parameter int TIMEOUT = 48000,
    parameter int TOW     = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [10:0] ps2_key,
    output logic        rx_err
);

    logic [7:0] rx_byte;
    logic       byte_vld;
    logic       frame_err;
    logic       ext;
    logic       brk;
    logic [2:0] skip;

    jtgng_ps2_rx #(
        .FILTER  (FILTER),
        .TIMEOUT (TIMEOUT),
        .TOW     (TOW)
    ) u_rx (
        .clk       (clk),
        .rst_n     (rst_n),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .rx_byte   (rx_byte),
        .byte_vld  (byte_vld),
        .frame_err (frame_err)
    );

    // Prefix decoder and key-word register; errors flush any pending prefix state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ps2_key <= '0;
            rx_err  <= 1'b0;
            ext     <= 1'b0;
            brk     <= 1'b0;
            skip    <= '0;
        end else begin
            rx_err <= frame_err;
            if (frame_err) begin
                ext  <= 1'b0;
                brk  <= 1'b0;
                skip <= '0;
            end else if (byte_vld) begin
                if (skip != 3'd0) begin
                    skip <= skip - 3'd1;
                end else begin
                    case (rx_byte)
                        PS2_EXT:   ext <= 1'b1;
                        PS2_BRK:   brk <= 1'b1;
                        PS2_PAUSE: begin
                            skip <= PAUSE_TAIL;
                            ext  <= 1'b0;
                            brk  <= 1'b0;
                        end
                        default: begin
                            ps2_key <= {~ps2_key[10], ~brk, ext, rx_byte};
                            ext     <= 1'b0;
                            brk     <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_jtgng_ps2_keydec.sv
// Directed bench for jtgng_ps2_keydec. The PS/2 clock runs much faster than a
// real keyboard so the whole sequence, including a full timeout, stays short.
module tb_jtgng_ps2_keydec;

    localparam int HP  = 40;   // PS/2 half period in clk cycles
    localparam int GAP = 100;  // idle cycles between frames

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ps2_clk;
    logic        ps2_data;
    logic [10:0] ps2_key;
    logic        rx_err;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int err_cnt  = 0;
    int last_fall_cyc = 0;

    jtgng_ps2_keydec dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .ps2_key  (ps2_key),
        .rx_err   (rx_err)
    );

    always #10 clk = ~clk;

    // Free-running cycle count and count of cycles with rx_err high
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rx_err) err_cnt <= err_cnt + 1;
    end

    initial begin
        #4_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One PS/2 bit: data changes while clock is high, device drops clock to present it
    task automatic send_bit(input logic b, input bit glitch);
        @(negedge clk);
        ps2_data = b;
        repeat (HP/2) @(negedge clk);
        if (glitch) begin
            ps2_clk = 1'b0;
            repeat (2) @(negedge clk);
            ps2_clk = 1'b1;
        end
        repeat (HP/2) @(negedge clk);
        ps2_clk = 1'b0;
        last_fall_cyc = cyc;
        repeat (HP) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bad_par, input bit glitch);
        logic par;
        par = ~(^b) ^ bad_par;
        send_bit(1'b0, glitch);
        for (int i = 0; i < 8; i++) send_bit(b[i], glitch);
        send_bit(par, glitch);
        send_bit(1'b1, glitch);
        repeat (GAP) @(negedge clk);
    endtask

    initial begin
        int  e0;
        int  delta;
        bit  seen;
        logic [7:0] pause_seq [8];
        pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};

        rst_n    = 1'b0;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        repeat (5) @(negedge clk);
        check("reset_key", 32'(ps2_key), 32'h0);
        check("reset_err", 32'(rx_err), 32'h0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        // Plain make code
        e0 = err_cnt;
        send_byte(8'h1C, 1'b0, 1'b0);
        check("make_1c", 32'(ps2_key), 32'h61C);
        check("make_1c_err", 32'(err_cnt - e0), 32'd0);

        // Extended make: prefix alone produces nothing
        send_byte(8'hE0, 1'b0, 1'b0);
        check("ext_prefix_hold", 32'(ps2_key), 32'h61C);
        send_byte(8'h75, 1'b0, 1'b0);
        check("ext_make_75", 32'(ps2_key), 32'h375);

        // Extended break
        e0 = err_cnt;
        send_byte(8'hE0, 1'b0, 1'b0);
        send_byte(8'hF0, 1'b0, 1'b0);
        check("ext_brk_hold", 32'(ps2_key), 32'h375);
        send_byte(8'h75, 1'b0, 1'b0);
        check("ext_break_75", 32'(ps2_key), 32'h575);
        check("ext_break_err", 32'(err_cnt - e0), 32'd0);

        // Parity error: one-cycle rx_err, key untouched
        e0 = err_cnt;
        send_byte(8'h29, 1'b1, 1'b0);
        check("par_err_pulse", 32'(err_cnt - e0), 32'd1);
        check("par_err_key", 32'(ps2_key), 32'h575);
        send_byte(8'h29, 1'b0, 1'b0);
        check("after_par_29", 32'(ps2_key), 32'h229);

        // Stall after 5 data bits of 0x14 (LSB first 0,0,1,0,1)
        e0 = err_cnt;
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 50000 && !seen; i++) begin
            @(negedge clk);
            if (rx_err) seen = 1'b1;
        end
        delta = cyc - last_fall_cyc;
        check("timeout_seen", 32'(seen), 32'd1);
        check("timeout_window", 32'(delta >= 47995 && delta <= 48020), 32'd1);
        repeat (GAP) @(negedge clk);
        check("timeout_pulse", 32'(err_cnt - e0), 32'd1);
        check("timeout_key", 32'(ps2_key), 32'h229);
        send_byte(8'h14, 1'b0, 1'b0);
        check("after_to_14", 32'(ps2_key), 32'h614);

        // Short low glitches on ps2_clk while idle and inside every bit
        e0 = err_cnt;
        ps2_clk = 1'b0;
        repeat (2) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (20) @(negedge clk);
        send_byte(8'h33, 1'b0, 1'b1);
        check("glitch_33", 32'(ps2_key), 32'h233);
        check("glitch_err", 32'(err_cnt - e0), 32'd0);

        // Pause sequence produces no event
        e0 = err_cnt;
        for (int i = 0; i < 8; i++) send_byte(pause_seq[i], 1'b0, 1'b0);
        check("pause_hold", 32'(ps2_key), 32'h233);
        check("pause_err", 32'(err_cnt - e0), 32'd0);
        send_byte(8'h05, 1'b0, 1'b0);
        check("after_pause_05", 32'(ps2_key), 32'h605);

        // Reset in the middle of a frame
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst_key", 32'(ps2_key), 32'h0);
        check("midrst_err", 32'(rx_err), 32'h0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        e0 = err_cnt;
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        repeat (GAP) @(negedge clk);
        check("bad_start_errs", 32'(err_cnt - e0), 32'd2);
        check("bad_start_key", 32'(ps2_key), 32'h0);
        send_byte(8'h05, 1'b0, 1'b0);
        check("resync_05", 32'(ps2_key), 32'h605);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
